gelato_ifetch: RTL and testbench
================================

Name: gelato_ifetch

Overview:
- Instruction fetch unit of the Gelato frontend; slave end of the fetch-scheduler → ifetch PC channel (modport gelato_fetchskd_ifetch_if.slave).
- Accepts one {pc, warp_num, split_table_num} tuple at a time, issues a word read to the instruction cache and waits for the response.
- Presents the fetched instruction, tagged with its warp context, to the decoder; supports per-warp flush on branch redirect.
- One fetch outstanding at a time; inst_pc_ready is the back-pressure the scheduler advances on.

Parameters:
- ADDR_WIDTH, 32, PC and instruction-cache address width.
- INST_WIDTH, 32, instruction word width.
- WARP_NUM_WIDTH, 5, warp number width (32 warps).
- SPLIT_NUM_WIDTH, 3, split-table index width.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; when 0, all state and outputs hold.
- inst_pc_valid  in  1  scheduler tuple valid.
- inst_pc_ready  out  1  unit can accept a tuple.
- inst_pc_pc  in  ADDR_WIDTH  fetch PC.
- inst_pc_warp_num  in  WARP_NUM_WIDTH  warp of the PC.
- inst_pc_split_table_num  in  SPLIT_NUM_WIDTH  split-table entry of the warp.
- icache_req_valid  out  1  read request valid.
- icache_req_ready  in  1  cache accepts request.
- icache_req_addr  out  ADDR_WIDTH  word-aligned address, {pc[ADDR_WIDTH-1:2], 2'b00}.
- icache_rsp_valid  in  1  read data valid (single-cycle pulse; no rsp ready).
- icache_rsp_data  in  INST_WIDTH  instruction word.
- flush_valid  in  1  redirect: discard the in-flight fetch of flush_warp_num.
- flush_warp_num  in  WARP_NUM_WIDTH  warp being redirected.
- inst_valid  out  1  fetched instruction valid to decoder.
- inst_ready  in  1  decoder accepts.
- inst_data  out  INST_WIDTH  instruction word.
- inst_pc  out  ADDR_WIDTH  PC of instruction (unaligned bits preserved).
- inst_warp_num  out  WARP_NUM_WIDTH  warp tag.
- inst_split_table_num  out  SPLIT_NUM_WIDTH  split-table tag.
- inst_misaligned  out  1  pc[1:0] != 0.

Behaviour:
- Reset: state=IDLE; inst_pc_ready=1; icache_req_valid=0; inst_valid=0; all data/tag outputs 0.
- The PC, tag and data registers are captured only on the transfers listed below. Tag and data outputs are don't-care while inst_valid=0.
- States:
  - IDLE: inst_pc_ready=1. Transfer when rdy & inst_pc_valid. Latch {pc, warp, split} and go to REQ.
  - REQ: icache_req_valid=1, address from the latched PC. On rdy & icache_req_ready go to WAIT.
  - WAIT: on rdy & icache_rsp_valid, latch icache_rsp_data into inst_data and go to OUT.
  - OUT: inst_valid=1. On rdy & inst_ready go to IDLE.
  - DRAIN: wait for the response, discard it, then go to IDLE.
- inst_pc_ready, icache_req_valid and inst_valid are decoded from the registered state.
- Minimum latency: tuple accepted in cycle N; request in N+1; if the cache accepts in N+1 and responds in N+2, inst_valid=1 in N+3. Next tuple is accepted the cycle after the decoder handshake.
- A response arriving in the same cycle as the request handshake is illegal; the cache responds one cycle or more after acceptance.
- Flush applies only when rdy & flush_valid & flush_warp_num == latched warp:
  - REQ without request handshake that cycle → IDLE; no request is issued.
  - REQ with request handshake that cycle → DRAIN.
  - WAIT without response → DRAIN.
  - WAIT with response that cycle → IDLE; data dropped.
  - OUT → IDLE; inst_valid=0 next cycle, even if inst_ready=1 in the same cycle.
  - A flush for a different warp is ignored. In IDLE, flush is ignored and the incoming tuple is still accepted.
- rdy=0 freezes everything, including flush and response capture. The cache must not assert rsp_valid while rdy=0.
- rst asserted mid-fetch returns to the reset values next cycle. A response for an abandoned request arriving after reset is ignored, because IDLE ignores rsp_valid.

Optional Feature:
GELATO_IFETCH_PERF_EN
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt increments on every decoder handshake.
  - perf_stall_cnt increments on every rdy cycle in REQ, WAIT or DRAIN.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single fetch: pc=0x0000_0100, warp=3, split=1; cache ready, rsp 1 cycle later with data 0x0010_0093; inst_ready=1 → inst_valid in N+3 with data 0x0010_0093, pc 0x100, warp 3, split 1; inst_pc_ready back to 1 at N+4.
- Back-pressure: hold icache_req_ready=0 for 4 cycles, then inst_ready=0 for 3 cycles → req_addr stable at 0x100; outputs stable; inst_pc_ready=0 throughout; exactly one fetch completes.
- Flush in WAIT: warp 7 fetch outstanding, flush_warp_num=7 → DRAIN; response 0xDEAD_BEEF dropped; inst_valid never asserts; IDLE after the response.
- Non-matching flush: warp 7 in OUT, flush_warp_num=2 → instruction still delivered to the decoder.
- rdy gating: rdy=0 for 5 cycles while in OUT with inst_ready=1 → no handshake; state holds; delivered on the first rdy=1 cycle.
- Misaligned/perf: pc=0x102 → icache_req_addr=0x100, inst_pc=0x102, inst_misaligned=1; with GELATO_IFETCH_PERF_EN defined, perf_fetch_cnt=1 after delivery.

Source files
------------

// File: rtl/gelato_ifetch_if.sv
// gelato_fetchskd_ifetch_if: fetch-scheduler -> ifetch PC channel carrying one {pc, warp, split} tuple per handshake.
interface gelato_fetchskd_ifetch_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int WARP_NUM_WIDTH  = 5,
    parameter int SPLIT_NUM_WIDTH = 3
);
    logic                       inst_pc_valid;
    logic                       inst_pc_ready;
    logic [ADDR_WIDTH-1:0]      inst_pc_pc;
    logic [WARP_NUM_WIDTH-1:0]  inst_pc_warp_num;
    logic [SPLIT_NUM_WIDTH-1:0] inst_pc_split_table_num;
    modport master (
        output inst_pc_valid, inst_pc_pc, inst_pc_warp_num, inst_pc_split_table_num,
        input  inst_pc_ready
    );
    modport slave (
        input  inst_pc_valid, inst_pc_pc, inst_pc_warp_num, inst_pc_split_table_num,
        output inst_pc_ready
    );
endinterface

// File: rtl/gelato_ifetch.sv
// gelato_ifetch: single-outstanding instruction fetch unit with per-warp flush.
// Define GELATO_IFETCH_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
module gelato_ifetch #(
    parameter int ADDR_WIDTH      = 32,
    parameter int INST_WIDTH      = 32,
    parameter int WARP_NUM_WIDTH  = 5,
    parameter int SPLIT_NUM_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    gelato_fetchskd_ifetch_if.slave    pc_if,
    output logic                       icache_req_valid,
    input  logic                       icache_req_ready,
    output logic [ADDR_WIDTH-1:0]      icache_req_addr,
    input  logic                       icache_rsp_valid,
    input  logic [INST_WIDTH-1:0]      icache_rsp_data,
    input  logic                       flush_valid,
    input  logic [WARP_NUM_WIDTH-1:0]  flush_warp_num,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [INST_WIDTH-1:0]      inst_data,
    output logic [ADDR_WIDTH-1:0]      inst_pc,
    output logic [WARP_NUM_WIDTH-1:0]  inst_warp_num,
    output logic [SPLIT_NUM_WIDTH-1:0] inst_split_table_num,
    output logic                       inst_misaligned
`ifdef GELATO_IFETCH_PERF_EN
    ,
    output logic [31:0]                perf_fetch_cnt,
    output logic [31:0]                perf_stall_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DRAIN} state_e;
    state_e                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      pc_q, pc_d;
    logic [WARP_NUM_WIDTH-1:0]  warp_q, warp_d;
    logic [SPLIT_NUM_WIDTH-1:0] split_q, split_d;
    logic [INST_WIDTH-1:0]      data_q, data_d;
    logic                       flush_hit;
    assign flush_hit = rdy && flush_valid && flush_warp_num == warp_q;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        warp_d  = warp_q;
        split_d = split_q;
        data_d  = data_q;
        if (rdy) begin
            case (state_q)
                IDLE: if (pc_if.inst_pc_valid) begin
                    pc_d    = pc_if.inst_pc_pc;
                    warp_d  = pc_if.inst_pc_warp_num;
                    split_d = pc_if.inst_pc_split_table_num;
                    state_d = REQ;
                end
                // a flushed request that was already accepted must still have its response drained
                REQ: state_d = flush_hit ? (icache_req_ready ? DRAIN : IDLE) : (icache_req_ready ? WAIT : REQ);
                WAIT: begin
                    data_d  = (icache_rsp_valid && !flush_hit) ? icache_rsp_data : data_q;
                    state_d = icache_rsp_valid ? (flush_hit ? IDLE : OUT) : (flush_hit ? DRAIN : WAIT);
                end
                OUT: state_d = (flush_hit || inst_ready) ? IDLE : OUT;
                DRAIN: state_d = icache_rsp_valid ? IDLE : DRAIN;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            warp_q  <= '0;
            split_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            warp_q  <= warp_d;
            split_q <= split_d;
            data_q  <= data_d;
        end
    end
    assign pc_if.inst_pc_ready   = state_q == IDLE;
    assign icache_req_valid      = state_q == REQ;
    assign icache_req_addr       = {pc_q[ADDR_WIDTH-1:2], 2'b00};
    assign inst_valid            = state_q == OUT;
    assign inst_data             = data_q;
    assign inst_pc               = pc_q;
    assign inst_warp_num         = warp_q;
    assign inst_split_table_num  = split_q;
    assign inst_misaligned       = |pc_q[1:0];
`ifdef GELATO_IFETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
    // a flushed instruction is dropped, so it does not count as fetched
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(rdy && state_q == OUT && inst_ready && !flush_hit);
        stall_cnt_d = stall_cnt_q + 32'(rdy && state_q inside {REQ, WAIT, DRAIN});
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_gelato_ifetch.sv
// tb_gelato_ifetch: directed and randomized fetch transactions checked against a transaction-level model.
module tb_gelato_ifetch;
    localparam int AW = 32, IW = 32, WW = 5, SW = 3;
    logic clk = 1'b0;
    logic rst, rdy;
    logic icache_req_valid, icache_req_ready, icache_rsp_valid;
    logic [AW-1:0] icache_req_addr;
    logic [IW-1:0] icache_rsp_data;
    logic flush_valid;
    logic [WW-1:0] flush_warp_num;
    logic inst_valid, inst_ready, inst_misaligned;
    logic [IW-1:0] inst_data;
    logic [AW-1:0] inst_pc;
    logic [WW-1:0] inst_warp_num;
    logic [SW-1:0] inst_split_table_num;
`ifdef GELATO_IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif
    int checks = 0, errors = 0;
    int r_ndel, r_nreq, r_nvalid;
    logic [IW-1:0] r_data;
    logic [AW-1:0] r_pc, r_addr;
    logic [WW-1:0] r_w;
    logic [SW-1:0] r_s;
    logic r_mis;
    bit r_unstable, r_tout;

    always #5 clk = ~clk;

    gelato_fetchskd_ifetch_if #(.ADDR_WIDTH(AW), .WARP_NUM_WIDTH(WW), .SPLIT_NUM_WIDTH(SW)) pc_if ();

    gelato_ifetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .WARP_NUM_WIDTH(WW), .SPLIT_NUM_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .pc_if(pc_if.slave),
        .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready), .icache_req_addr(icache_req_addr),
        .icache_rsp_valid(icache_rsp_valid), .icache_rsp_data(icache_rsp_data),
        .flush_valid(flush_valid), .flush_warp_num(flush_warp_num),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_warp_num(inst_warp_num), .inst_split_table_num(inst_split_table_num), .inst_misaligned(inst_misaligned)
`ifdef GELATO_IFETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        rdy = 1'b1;
        pc_if.inst_pc_valid = 1'b0;
        icache_req_ready = 1'b0;
        icache_rsp_valid = 1'b0;
        flush_valid = 1'b0;
        inst_ready = 1'b0;
    endtask

    // Acts as scheduler, cache and decoder for one tuple; flush fires once in the chosen phase:
    // 1 REQ stalled, 2 REQ handshake, 3 WAIT before response, 4 with response, 5 OUT, 6 IDLE.
    task automatic fetch_txn(input logic [AW-1:0] pc, input logic [WW-1:0] w, input logic [SW-1:0] s,
                             input logic [IW-1:0] d, input int req_wait, input int rsp_wait, input int dec_wait,
                             input int fphase, input logic [WW-1:0] fw, input bit rdy_rand);
        int reqc = 0, decc = 0, cnt = 0, cyc = 0;
        bit sent = 0, pending = 0, fired = 0, hs, seen_req = 0, seen_out = 0;
        logic [IW+AW+WW+SW:0] snap = '0, cur;
        r_ndel = 0; r_nreq = 0; r_nvalid = 0; r_unstable = 0; r_tout = 0;
        r_data = '0; r_pc = '0; r_w = '0; r_s = '0; r_mis = 1'b0; r_addr = '0;
        pc_if.inst_pc_pc = pc;
        pc_if.inst_pc_warp_num = w;
        pc_if.inst_pc_split_table_num = s;
        icache_rsp_data = d;
        while (!(sent && pc_if.inst_pc_ready && !pending)) begin
            if (cyc++ > 300) begin
                r_tout = 1;
                break;
            end
            if (icache_req_valid) begin
                if (seen_req && icache_req_addr !== r_addr) r_unstable = 1;
                r_addr = icache_req_addr;
                seen_req = 1;
            end
            if (inst_valid) begin
                cur = {inst_data, inst_pc, inst_warp_num, inst_split_table_num, inst_misaligned};
                if (seen_out && cur !== snap) r_unstable = 1;
                snap = cur;
                seen_out = 1;
                r_nvalid++;
            end
            rdy = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
            pc_if.inst_pc_valid = !sent;
            icache_rsp_valid = 1'b0;
            flush_valid = 1'b0;
            flush_warp_num = w;
            hs = 0;
            if (!rdy) begin
                icache_req_ready = 1'($urandom);
                inst_ready = 1'($urandom);
                flush_valid = 1'($urandom);
            end else begin
                if (pending) begin
                    if (cnt == 0) begin
                        icache_rsp_valid = 1'b1;
                        pending = 0;
                    end else cnt--;
                end
                icache_req_ready = 1'b0;
                if (icache_req_valid) begin
                    if (reqc < req_wait) reqc++;
                    else begin
                        icache_req_ready = 1'b1;
                        hs = 1;
                        r_nreq++;
                    end
                end
                inst_ready = 1'b0;
                if (inst_valid) begin
                    if (decc < dec_wait) decc++;
                    else inst_ready = 1'b1;
                end
                if (!fired && ((fphase == 1 && icache_req_valid && !icache_req_ready) || (fphase == 2 && hs) ||
                               (fphase == 3 && pending && !hs) || (fphase == 4 && icache_rsp_valid) ||
                               (fphase == 5 && inst_valid) || (fphase == 6 && !sent))) begin
                    fired = 1;
                    flush_valid = 1'b1;
                    flush_warp_num = fw;
                end
                if (inst_valid && inst_ready && !(flush_valid && flush_warp_num == w)) begin
                    r_ndel++;
                    {r_data, r_pc, r_w, r_s, r_mis} = {inst_data, inst_pc, inst_warp_num, inst_split_table_num, inst_misaligned};
                end
                if (hs) begin
                    pending = 1;
                    cnt = rsp_wait;
                end
                if (!sent && pc_if.inst_pc_ready) sent = 1;
            end
            tick;
        end
        idle_inputs;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        checks++;
        if ({pc_if.inst_pc_ready, icache_req_valid, inst_valid} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 100", {pc_if.inst_pc_ready, icache_req_valid, inst_valid});
        end
        checks++;
        if ({inst_data, inst_pc, inst_warp_num, inst_split_table_num, inst_misaligned, icache_req_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data: data=%h pc=%h w=%0d s=%0d mis=%b addr=%h expected all 0",
                     inst_data, inst_pc, inst_warp_num, inst_split_table_num, inst_misaligned, icache_req_addr);
        end
    endtask

    task automatic test_single;
        pc_if.inst_pc_valid = 1'b1;
        pc_if.inst_pc_pc = 32'h0000_0100;
        pc_if.inst_pc_warp_num = 5'd3;
        pc_if.inst_pc_split_table_num = 3'd1;
        inst_ready = 1'b1;
        tick;
        pc_if.inst_pc_valid = 1'b0;
        checks++;
        if ({icache_req_valid, pc_if.inst_pc_ready, icache_req_addr} !== {2'b10, 32'h100}) begin
            errors++;
            $display("FAIL single_req: req_valid=%b pc_ready=%b addr=%h expected 1 0 00000100",
                     icache_req_valid, pc_if.inst_pc_ready, icache_req_addr);
        end
        icache_req_ready = 1'b1;
        tick;
        icache_req_ready = 1'b0;
        icache_rsp_valid = 1'b1;
        icache_rsp_data = 32'h0010_0093;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: inst_valid=%b expected 0 at N+2", inst_valid);
        end
        tick;
        icache_rsp_valid = 1'b0;
        checks++;
        if ({inst_valid, inst_data, inst_pc, inst_warp_num, inst_split_table_num, inst_misaligned} !==
            {1'b1, 32'h0010_0093, 32'h100, 5'd3, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_out: valid=%b data=%h pc=%h w=%0d s=%0d mis=%b expected 1 00100093 00000100 3 1 0",
                     inst_valid, inst_data, inst_pc, inst_warp_num, inst_split_table_num, inst_misaligned);
        end
        tick;
        inst_ready = 1'b0;
        checks++;
        if ({pc_if.inst_pc_ready, inst_valid} !== 2'b10) begin
            errors++;
            $display("FAIL single_done: pc_ready=%b inst_valid=%b expected 1 0", pc_if.inst_pc_ready, inst_valid);
        end
    endtask

    task automatic test_back_pressure;
        fetch_txn(32'h100, 5'd2, 3'd4, 32'h1234_5678, 4, 0, 3, 0, 5'd0, 1'b0);
        checks++;
        if (r_tout || r_unstable || r_ndel != 1 || r_nreq != 1 || r_addr !== 32'h100 || r_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL back_pressure: tout=%b unstable=%b ndel=%0d nreq=%0d addr=%h data=%h expected 0 0 1 1 00000100 12345678",
                     r_tout, r_unstable, r_ndel, r_nreq, r_addr, r_data);
        end
    endtask

    task automatic test_flush_wait;
        fetch_txn(32'h200, 5'd7, 3'd0, 32'hDEAD_BEEF, 0, 3, 0, 3, 5'd7, 1'b0);
        checks++;
        if (r_tout || r_ndel != 0 || r_nvalid != 0 || r_nreq != 1 || pc_if.inst_pc_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait: tout=%b ndel=%0d valid_cycles=%0d nreq=%0d pc_ready=%b expected 0 0 0 1 1",
                     r_tout, r_ndel, r_nvalid, r_nreq, pc_if.inst_pc_ready);
        end
    endtask

    task automatic test_flush_other;
        fetch_txn(32'h300, 5'd7, 3'd2, 32'hCAFE_0001, 0, 0, 2, 5, 5'd2, 1'b0);
        checks++;
        if (r_tout || r_ndel != 1 || r_data !== 32'hCAFE_0001 || r_w !== 5'd7) begin
            errors++;
            $display("FAIL flush_other: tout=%b ndel=%0d data=%h w=%0d expected 0 1 cafe0001 7", r_tout, r_ndel, r_data, r_w);
        end
    endtask

    task automatic test_rdy_gating;
        pc_if.inst_pc_valid = 1'b1;
        pc_if.inst_pc_pc = 32'h400;
        pc_if.inst_pc_warp_num = 5'd9;
        tick;
        pc_if.inst_pc_valid = 1'b0;
        icache_req_ready = 1'b1;
        tick;
        icache_req_ready = 1'b0;
        icache_rsp_valid = 1'b1;
        icache_rsp_data = 32'hA5A5_0F0F;
        tick;
        icache_rsp_valid = 1'b0;
        rdy = 1'b0;
        inst_ready = 1'b1;
        flush_valid = 1'b1;
        flush_warp_num = 5'd9;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if ({inst_valid, inst_data} !== {1'b1, 32'hA5A5_0F0F}) begin
                errors++;
                $display("FAIL rdy_hold[%0d]: valid=%b data=%h expected 1 a5a50f0f", i, inst_valid, inst_data);
            end
        end
        flush_valid = 1'b0;
        rdy = 1'b1;
        tick;
        inst_ready = 1'b0;
        checks++;
        if ({inst_valid, pc_if.inst_pc_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rdy_release: valid=%b pc_ready=%b expected 0 1", inst_valid, pc_if.inst_pc_ready);
        end
    endtask

    task automatic test_reset_midfetch;
        pc_if.inst_pc_valid = 1'b1;
        pc_if.inst_pc_pc = 32'h500;
        tick;
        pc_if.inst_pc_valid = 1'b0;
        icache_req_ready = 1'b1;
        tick;
        icache_req_ready = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({pc_if.inst_pc_ready, icache_req_valid, inst_valid, inst_pc} !== {3'b100, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid: pc_ready=%b req_valid=%b inst_valid=%b pc=%h expected 1 0 0 0",
                     pc_if.inst_pc_ready, icache_req_valid, inst_valid, inst_pc);
        end
        icache_rsp_valid = 1'b1;
        tick;
        icache_rsp_valid = 1'b0;
        checks++;
        if ({pc_if.inst_pc_ready, inst_valid} !== 2'b10) begin
            errors++;
            $display("FAIL stale_rsp: pc_ready=%b inst_valid=%b expected 1 0", pc_if.inst_pc_ready, inst_valid);
        end
    endtask

    task automatic test_misaligned;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        fetch_txn(32'h102, 5'd1, 3'd5, 32'h0000_0013, 0, 0, 0, 0, 5'd0, 1'b0);
        checks++;
        if (r_tout || r_ndel != 1 || r_addr !== 32'h100 || r_pc !== 32'h102 || r_mis !== 1'b1) begin
            errors++;
            $display("FAIL misaligned: tout=%b ndel=%0d addr=%h pc=%h mis=%b expected 0 1 00000100 00000102 1",
                     r_tout, r_ndel, r_addr, r_pc, r_mis);
        end
`ifdef GELATO_IFETCH_PERF_EN
        checks++;
        if (perf_fetch_cnt !== 32'd1 || perf_stall_cnt !== 32'd2) begin
            errors++;
            $display("FAIL perf: fetch=%0d stall=%0d expected 1 2", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
    endtask

    task automatic test_random;
        logic [AW-1:0] pc;
        logic [IW-1:0] d;
        logic [WW-1:0] w, fw;
        logic [SW-1:0] s;
        int fp;
        bit kill;
        for (int i = 0; i < 80; i++) begin
            pc = $urandom;
            d = $urandom;
            s = 3'($urandom);
            w = 5'($urandom_range(3));
            fw = 5'($urandom_range(3));
            fp = $urandom_range(6);
            fetch_txn(pc, w, s, d, $urandom_range(3) + int'(fp == 1), $urandom_range(3) + int'(fp == 3),
                      $urandom_range(2), fp, fw, 1'($urandom));
            kill = fp >= 1 && fp <= 5 && fw == w;
            checks++;
            if (r_tout || r_ndel != (kill ? 0 : 1)) begin
                errors++;
                $display("FAIL rand_deliver[%0d]: tout=%b ndel=%0d expected 0 %0d (phase %0d)", i, r_tout, r_ndel, kill ? 0 : 1, fp);
            end
            checks++;
            if (r_nreq != ((kill && fp == 1) ? 0 : 1)) begin
                errors++;
                $display("FAIL rand_req[%0d]: nreq=%0d expected %0d (phase %0d)", i, r_nreq, (kill && fp == 1) ? 0 : 1, fp);
            end
            if (kill && fp < 5) begin
                checks++;
                if (r_nvalid != 0) begin
                    errors++;
                    $display("FAIL rand_killed_valid[%0d]: valid_cycles=%0d expected 0", i, r_nvalid);
                end
            end
            if (!kill) begin
                checks++;
                if ({r_data, r_pc, r_w, r_s, r_mis} !== {d, pc, w, s, pc[1:0] != 2'b00}) begin
                    errors++;
                    $display("FAIL rand_fields[%0d]: got %h %h %0d %0d %b expected %h %h %0d %0d %b",
                             i, r_data, r_pc, r_w, r_s, r_mis, d, pc, w, s, pc[1:0] != 2'b00);
                end
            end
            if (!(kill && fp == 1)) begin
                checks++;
                if (r_addr !== {pc[AW-1:2], 2'b00} || r_unstable) begin
                    errors++;
                    $display("FAIL rand_addr[%0d]: addr=%h unstable=%b expected %h 0", i, r_addr, r_unstable, {pc[AW-1:2], 2'b00});
                end
            end
        end
    endtask

    initial begin
        idle_inputs;
        rst = 1'b1;
        pc_if.inst_pc_pc = '0;
        pc_if.inst_pc_warp_num = '0;
        pc_if.inst_pc_split_table_num = '0;
        icache_rsp_data = '0;
        flush_warp_num = '0;
        test_reset;
        test_single;
        test_back_pressure;
        test_flush_wait;
        test_flush_other;
        test_rdy_gating;
        test_reset_midfetch;
        test_misaligned;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
